// File: rtl/controller_emulator.sv
// Purpose: emulates one NES-style gamepad on the console's serial controller port.
// Latency: console clk/latch edge to serial_no change is SYNC_STAGES+2 clk cycles.
// Backpressure: host_ready_o is low while one button value is pending; the slot frees on each latch rise.
//
// Ports: clk, rst_ni (synchronous, active-low)
//        host_buttons_i/host_valid_i/host_ready_o : host button handshake (bit 7 = A ... bit 0 = Right)
//        controller_clk_i/controller_latch_i      : asynchronous console shift clock and load strobe
//        serial_no                                : registered active-low serial data
//        poll_count_o / stale_o                   : completed polls, and no poll for TIMEOUT_CYCLES
module controller_emulator #(
    parameter int   SYNC_STAGES    = 2,
    parameter logic FILL_LEVEL     = 1'b1,
    parameter int   TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic [7:0]  host_buttons_i,
    input  logic        host_valid_i,
    output logic        host_ready_o,
    input  logic        controller_clk_i,
    input  logic        controller_latch_i,
    output logic        serial_no,
    output logic [15:0] poll_count_o,
    output logic        stale_o
);
    localparam int            TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DRAIN} state_t;

    // Synchronizers: bit 0 takes the raw input, bit SYNC_STAGES-1 is the settled value.
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic                   r_clk_prev;
    logic                   r_latch_prev;
    logic                   w_clk_rise;
    logic                   w_latch_rise;
    logic                   w_latch_fall;

    state_t        r_state;
    logic [7:0]    r_active;
    logic [7:0]    r_pending;
    logic          r_pend_full;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic [15:0]   r_poll_cnt;
    logic          r_serial;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_next;
    logic          r_stale;
    logic          w_accept;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_clk_sync   <= '0;
            r_latch_sync <= '0;
            r_clk_prev   <= 1'b0;
            r_latch_prev <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], controller_clk_i};
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], controller_latch_i};
            r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
            r_latch_prev <= r_latch_sync[SYNC_STAGES-1];
        end
    end

    assign w_clk_rise   =  r_clk_sync[SYNC_STAGES-1]   && !r_clk_prev;
    assign w_latch_rise =  r_latch_sync[SYNC_STAGES-1] && !r_latch_prev;
    assign w_latch_fall = !r_latch_sync[SYNC_STAGES-1] &&  r_latch_prev;
    assign w_accept     =  host_valid_i && !r_pend_full;

    // Stale timer saturates; stale_o is derived from the next value so it
    // asserts on the same edge the timer reaches TIMEOUT_CYCLES.
    always_comb begin
        w_timer_next = r_timer;
        if (w_latch_rise) begin
            w_timer_next = '0;
        end else if (r_timer != TIMEOUT_VAL) begin
            w_timer_next = r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_timer <= '0;
            r_stale <= 1'b0;
        end else begin
            r_timer <= w_timer_next;
            r_stale <= (w_timer_next == TIMEOUT_VAL);
        end
    end

    // Host slot and poll FSM. The slot hands over to r_active on the latch
    // rise itself, so a value offered after that waits for the next poll.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_active    <= 8'h00;
            r_pending   <= 8'h00;
            r_pend_full <= 1'b0;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_poll_cnt  <= 16'h0000;
            r_serial    <= FILL_LEVEL;
        end else begin
            if (w_latch_rise) begin
                if (r_pend_full) begin
                    r_active    <= r_pending;
                    r_pend_full <= 1'b0;
                end else if (w_accept) begin
                    // Value arriving with the latch goes straight to this poll.
                    r_active <= host_buttons_i;
                end
            end else if (w_accept) begin
                r_pending   <= host_buttons_i;
                r_pend_full <= 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    r_serial <= FILL_LEVEL;
                    if (w_latch_rise) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_serial <= ~r_active[7];
                    r_shift  <= r_active;
                    if (!w_latch_rise && w_latch_fall) begin
                        r_state    <= ST_SHIFT;
                        r_bit_cnt  <= 3'd0;
                        r_poll_cnt <= r_poll_cnt + 16'd1;
                    end
                end
                ST_SHIFT: begin
                    r_serial <= ~r_shift[7];
                    // Latch rise takes priority over a coincident clk rise.
                    if (w_latch_rise) begin
                        r_state <= ST_LOAD;
                    end else if (w_clk_rise) begin
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_serial <= FILL_LEVEL;
                    if (w_latch_rise) r_state <= ST_LOAD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host_ready_o = !r_pend_full;
    assign serial_no    = r_serial;
    assign poll_count_o = r_poll_cnt;
    assign stale_o      = r_stale;

endmodule
